// File: rtl/rls_core.sv
// RLS inner-product engine: serially loaded weight/regressor vectors, one shared
// multiplier, saturated registered result with a one-cycle valid strobe.
module rls_core #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] y,
  input  logic         load,
  input  logic         seleccion,
  input  logic         shift,
  input  logic         en1,
  output logic [W-1:0] s,
  output logic         x
);

  // Accumulator keeps every bit of a full-scale product plus headroom for up to 256 taps.
  localparam int AW = 2*W - FRAC + 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_t;

  state_t               r_state, w_state_next;
  logic [W-1:0]         r_w   [N];
  logic [W-1:0]         r_phi [N];
  logic [W-1:0]         w_w_in   [N];
  logic [W-1:0]         w_phi_in [N];
  logic signed [AW-1:0] r_acc;
  logic [IW-1:0]        r_idx;
  logic [W-1:0]         r_s;
  logic                 r_x;

  logic                 w_idle, w_last, w_load_w, w_shift_phi;
  logic [W-1:0]         w_wsel, w_phisel;
  logic [2*W-1:0]       w_prod;
  logic signed [2*W-1:0] w_prod_shr;
  logic signed [AW-1:0] w_p, w_sum;
  logic                 w_in_range;
  logic [W-1:0]         w_sat;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_last      = (r_idx == IW'(N-1));
  assign w_load_w    = w_idle && load && !seleccion;
  assign w_shift_phi = w_idle && ((load && seleccion) || shift);

  // Tap 0 takes the new sample, every other tap takes its lower neighbour.
  for (genvar gi = 0; gi < N; gi++) begin : g_tap
    if (gi == 0) begin : g_head
      assign w_w_in[gi]   = y;
      assign w_phi_in[gi] = y;
    end else begin : g_body
      assign w_w_in[gi]   = r_w[gi-1];
      assign w_phi_in[gi] = r_phi[gi-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_w[gi]   <= '0;
        r_phi[gi] <= '0;
      end else begin
        if (w_load_w)    r_w[gi]   <= w_w_in[gi];
        if (w_shift_phi) r_phi[gi] <= w_phi_in[gi];
      end
    end
  end

  assign w_wsel     = r_w[r_idx];
  assign w_phisel   = r_phi[r_idx];
  assign w_prod     = {{W{w_wsel[W-1]}}, w_wsel} * {{W{w_phisel[W-1]}}, w_phisel};
  assign w_prod_shr = $signed(w_prod) >>> FRAC;
  assign w_p        = AW'(w_prod_shr);
  assign w_sum      = r_acc + w_p;

  // In range when every bit above the result sign bit agrees with it.
  assign w_in_range = (&w_sum[AW-1:W-1]) || !(|w_sum[AW-1:W-1]);
  assign w_sat      = w_in_range ? w_sum[W-1:0]
                    : (w_sum[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (en1) w_state_next = ST_MAC;
      ST_MAC:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_idx <= '0;
      r_s   <= '0;
      r_x   <= 1'b0;
    end else begin
      r_x <= (r_state == ST_MAC) && w_last;
      if (w_idle && en1) begin
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == ST_MAC) begin
        r_acc <= w_sum;
        r_idx <= r_idx + IW'(1);
        if (w_last) r_s <= w_sat;
      end
    end
  end

  assign s = r_s;
  assign x = r_x;

endmodule

// File: tb/tb_rls_core.sv
// Randomised and directed bench for rls_core: a driver feeds stimulus into a
// tap-level reference model, a monitor pops expected results whenever x should fire.
module tb_rls_core;
  localparam int W = 32;
  localparam int N = 4;
  localparam int FRAC = 16;

  logic clk = 1'b0;
  logic reset = 1'b1, load = 1'b0, seleccion = 1'b0, shift = 1'b0, en1 = 1'b0;
  logic [W-1:0] y = '0;
  logic [W-1:0] s;
  logic x;

  rls_core #(.W(W), .N(N), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .y(y), .load(load), .seleccion(seleccion),
    .shift(shift), .en1(en1), .s(s), .x(x)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] val;
    int           e;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int free_edge = 0;
  logic signed [W-1:0] mw [N];
  logic signed [W-1:0] mphi [N];
  logic [W-1:0] s_hold = '0;

  function automatic logic [W-1:0] model_ip();
    longint acc = 0;
    for (int k = 0; k < N; k++)
      acc += (longint'(mw[k]) * longint'(mphi[k])) >>> FRAC;
    if (acc > 64'sd2147483647)       return 32'h7FFF_FFFF;
    else if (acc < -64'sd2147483648) return 32'h8000_0000;
    else                             return acc[W-1:0];
  endfunction

  // One clock: drive inputs, take the edge, update the model, park after negedge.
  task automatic tick(input logic rst, input logic ld, input logic sel,
                      input logic sh, input logic en, input logic [W-1:0] yv);
    bit idle;
    reset = rst; load = ld; seleccion = sel; shift = sh; en1 = en; y = yv;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      for (int k = 0; k < N; k++) begin mw[k] = '0; mphi[k] = '0; end
      free_edge = edge_cnt + 1;
    end else begin
      idle = (edge_cnt >= free_edge);
      if (idle && ld && !sel) begin
        for (int k = N-1; k > 0; k--) mw[k] = mw[k-1];
        mw[0] = yv;
      end
      if (idle && ((ld && sel) || sh)) begin
        for (int k = N-1; k > 0; k--) mphi[k] = mphi[k-1];
        mphi[0] = yv;
      end
      if (idle && en) begin
        sb_q.push_back('{val: model_ip(), e: edge_cnt + N});
        free_edge = edge_cnt + N + 2;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, '0);
  endtask

  task automatic load4(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    tick(0, 1, sel, 0, 0, a);
    tick(0, 1, sel, 0, 0, b);
    tick(0, 1, sel, 0, 0, c);
    tick(0, 1, sel, 0, 0, d);
  endtask

  task automatic chk_s(input string nm, input logic [W-1:0] want);
    total++;
    if (s !== want) begin
      bad++;
      $display("FAIL %s: s=%h expected=%h", nm, s, want);
    end
  endtask

  // Monitor: inputs seen here are the ones applied at the edge just taken.
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      if (reset) begin
        total++;
        if (s !== '0 || x !== 1'b0) begin
          bad++;
          $display("FAIL reset_state: edge=%0d s=%h x=%b expected s=0 x=0", edge_cnt, s, x);
        end
        sb_q.delete();
        s_hold = '0;
      end else begin
        bit exp_x;
        exp_x = (sb_q.size() > 0) && (sb_q[0].e == edge_cnt);
        total++;
        if (x !== exp_x) begin
          bad++;
          $display("FAIL x_strobe: edge=%0d x=%b expected=%b", edge_cnt, x, exp_x);
        end
        total++;
        if (exp_x) begin
          if (s !== sb_q[0].val) begin
            bad++;
            $display("FAIL result: edge=%0d s=%h expected=%h", edge_cnt, s, sb_q[0].val);
          end else begin
            $display("result edge=%0d s=%h", edge_cnt, s);
          end
          s_hold = sb_q[0].val;
          void'(sb_q.pop_front());
        end else if (s !== s_hold) begin
          bad++;
          $display("FAIL s_hold: edge=%0d s=%h expected=%h", edge_cnt, s, s_hold);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    tick(1, 0, 0, 0, 0, '0);
    tick(1, 0, 0, 0, 0, '0);

    // Start with cleared vectors: result 0 on the fifth cycle.
    tick(0, 0, 0, 0, 1, '0);
    idle_n(7);
    chk_s("zero_vectors", 32'h0000_0000);

    load4(0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    load4(1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    tick(0, 0, 0, 0, 1, '0);
    idle_n(7);
    chk_s("sum_1234", 32'h000A_0000);

    // Shift accompanying the start is applied before the products are formed.
    tick(0, 0, 0, 1, 1, 32'h0002_0000);
    idle_n(7);
    chk_s("shift_and_start", 32'h000E_0000);

    load4(0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000);
    load4(1, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
    tick(0, 0, 0, 0, 1, '0);
    idle_n(7);
    chk_s("negative_half", 32'hFFFE_0000);

    load4(0, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    load4(1, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    tick(0, 0, 0, 0, 1, '0);
    idle_n(7);
    chk_s("sat_positive", 32'h7FFF_FFFF);

    load4(0, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000);
    tick(0, 0, 0, 0, 1, '0);
    idle_n(7);
    chk_s("sat_negative", 32'h8000_0000);

    // Vector writes while busy must be ignored.
    load4(0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    load4(1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    tick(0, 0, 0, 0, 1, '0);
    tick(0, 1, 0, 0, 0, 32'h1234_5678);
    tick(0, 1, 1, 0, 0, 32'h1234_5678);
    tick(0, 0, 0, 1, 0, 32'h1234_5678);
    tick(0, 1, 1, 1, 0, 32'h1234_5678);
    tick(0, 1, 0, 1, 1, 32'h1234_5678);
    idle_n(2);
    chk_s("busy_writes_ignored", 32'h000A_0000);
    tick(0, 0, 0, 0, 1, '0);
    idle_n(7);
    chk_s("vectors_intact", 32'h000A_0000);

    // Reset on the second MAC cycle aborts without a strobe.
    tick(0, 0, 0, 0, 1, '0);
    tick(0, 0, 0, 0, 0, '0);
    tick(1, 0, 0, 0, 0, '0);
    idle_n(6);
    chk_s("abort_reset", 32'h0000_0000);

    // en1 held high: back-to-back results every N+2 clocks.
    load4(0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    load4(1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, 1, '0);
    idle_n(7);
    chk_s("continuous_en1", 32'h000A_0000);

    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] yv;
      logic rst, ld, sel, sh, en;
      if ($urandom_range(0, 3) == 0) yv = $urandom;
      else yv = W'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      rst = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 1) == 1;
      sh  = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 4) == 0);
      tick(rst, ld, sel, sh, en, yv);
    end
    idle_n(10);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL pending_results: outstanding=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
